// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe. The master side drives
// operands and out_ready; the slave side (the pipeline) drives results and flags.
interface addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             is_sub;
  logic             flag_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic [2:0]       flag_out;
  logic [2:0]       flag_reg;

  modport master (
    output in_valid, a_in, b_in, is_sub, flag_en, out_ready,
    input  in_ready, out_valid, sum_out, flag_out, flag_reg
  );

  modport slave (
    input  in_valid, a_in, b_in, is_sub, flag_en, out_ready,
    output in_ready, out_valid, sum_out, flag_out, flag_reg
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/sub built from 4-bit CLA groups split evenly over NUM_STAGES registers.
// Define ADDSUB_SAT_EN to saturate on signed overflow; otherwise the result wraps.
module addsub_pipe #(
  parameter int WIDTH      = 16,
  parameter int NUM_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  addsub_pipe_if.slave  bus
);

  localparam int GROUPS = WIDTH / 4;
  localparam int GPS    = GROUPS / NUM_STAGES;
  localparam int LAST   = NUM_STAGES - 1;

  typedef struct packed {
    logic [3:0] sum;
    logic       c3;
    logic       c4;
  } cla_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             cmsb;
`ifdef ADDSUB_SAT_EN
    logic             sign;
`endif
    logic             flag_en;
  } stage_t;

  function automatic cla_t cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    cla_t       r;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    r.sum = p ^ c[3:0];
    r.c3  = c[3];
    r.c4  = c[4];
    return r;
  endfunction

  // Processes this stage's slice of groups, rippling the group carry through it.
  function automatic stage_t stage_fn(input stage_t st, input int s);
    stage_t res;
    cla_t   r;
    logic   c;
    int     idx;
    res = st;
    c   = st.carry;
    for (int g = 0; g < GPS; g++) begin
      idx = (s * GPS + g) * 4;
      r   = cla4(st.a[idx +: 4], st.b[idx +: 4], c);
      res.sum[idx +: 4] = r.sum;
      if (s == LAST) res.cmsb = r.c3;
      c = r.c4;
    end
    res.carry = c;
    return res;
  endfunction

  stage_t                stage_q  [NUM_STAGES];
  stage_t                stage_in [NUM_STAGES];
  stage_t                stage_d  [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_in;
  logic [NUM_STAGES-1:0] adv;
  logic [2:0]            flag_reg_q;
  logic [2:0]            flag_reg_d;
  logic [2:0]            flag_now;
  logic [WIDTH-1:0]      sum_res;
  logic                  ovf;
  logic                  retire;

  // NOTE: every always_comb output gets a full default first so no latch can be inferred.
  always_comb begin
    valid_in          = '0;
    stage_in[0]       = '0;
    stage_in[0].a     = bus.a_in;
    stage_in[0].b     = bus.is_sub ? ~bus.b_in : bus.b_in;
    stage_in[0].carry = bus.is_sub;
`ifdef ADDSUB_SAT_EN
    stage_in[0].sign  = bus.a_in[WIDTH-1];
`endif
    stage_in[0].flag_en = bus.flag_en;
    valid_in[0]         = bus.in_valid;
    for (int s = 1; s < NUM_STAGES; s++) begin
      stage_in[s] = stage_q[s-1];
      valid_in[s] = valid_q[s-1];
    end
    for (int s = 0; s < NUM_STAGES; s++) begin
      stage_d[s] = stage_fn(stage_in[s], s);
    end
  end

  // Backpressure ripples combinationally from out_ready down to in_ready.
  always_comb begin
    adv       = '0;
    adv[LAST] = ~valid_q[LAST] | bus.out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      adv[s] = ~valid_q[s] | adv[s+1];
    end
  end

  always_comb begin
    ovf     = stage_q[LAST].cmsb ^ stage_q[LAST].carry;
    sum_res = stage_q[LAST].sum;
`ifdef ADDSUB_SAT_EN
    if (ovf) sum_res = {stage_q[LAST].sign, {(WIDTH-1){~stage_q[LAST].sign}}};
`endif
    flag_now   = {sum_res[WIDTH-1], ovf, ~|sum_res};
    retire     = valid_q[LAST] & bus.out_ready;
    flag_reg_d = (retire && stage_q[LAST].flag_en) ? flag_now : flag_reg_q;
  end

  // NOTE: stage data is reset too, so sum_out/flag_out come up as 0 / 3'b001.
  // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      flag_reg_q <= '0;
      for (int s = 0; s < NUM_STAGES; s++) stage_q[s] <= '0;
    end else begin
      flag_reg_q <= flag_reg_d;
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (adv[s]) begin
          valid_q[s] <= valid_in[s];
          if (valid_in[s]) stage_q[s] <= stage_d[s];
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum_out   = sum_res;
  assign bus.flag_out  = flag_now;
  assign bus.flag_reg  = flag_reg_q;

endmodule
